// File: rtl/priority_encoder_4to2_reg_if.sv
// Grant handshake between the registered priority encoder and its consumer.
// The encoder drives the index and valid flag; the consumer drives ready.
interface priority_encoder_4to2_reg_if #(
  parameter int W = 2
);
  logic [W-1:0] out_idx;
  logic         out_valid;
  logic         out_ready;

  modport master (output out_idx, output out_valid, input out_ready);
  modport slave  (input out_idx, input out_valid, output out_ready);
endinterface

// File: rtl/priority_encoder_4to2_reg.sv
// Registered priority encoder with sticky pending requests and a valid/ready grant.
// Define PRIO_ENC_EDGE_DETECT_EN to capture only rising edges of req_in (default: level capture).
module priority_encoder_4to2_reg #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_en,
  input  logic [N-1:0]                  i_req_in,
  input  logic                          i_ovf_clr,
  output logic [N-1:0]                  o_pending,
  output logic                          o_ovf,
  priority_encoder_4to2_reg_if.master   grant_if
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [N-1:0]   r_pending;
  logic [W-1:0]   r_out_idx;
  logic           r_out_valid;
  logic           r_ovf;
  logic [W-1:0]   w_idx_next;
  logic           w_valid_next;
  logic [W-1:0]   w_high_idx;
  logic [N-1:0]   w_cap;
  logic [N-1:0]   w_cap_en;
  logic [N-1:0]   w_clr_mask;
  logic           w_accept;

`ifdef PRIO_ENC_EDGE_DETECT_EN
  logic [N-1:0]   r_req_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_req_q <= '0;
    else        r_req_q <= i_req_in;
  end

  assign w_cap = i_req_in & ~r_req_q;
`else
  assign w_cap = i_req_in;
`endif

  assign w_accept   = r_out_valid && grant_if.out_ready;
  assign w_clr_mask = w_accept ? ({{(N-1){1'b0}}, 1'b1} << r_out_idx) : '0;
  assign w_cap_en   = i_en ? w_cap : '0;

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    w_high_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (r_pending[i]) w_high_idx = W'(i);
    end
  end

  // A capture on the bit being accepted this cycle keeps it pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_clr_mask) | w_cap_en;
      if (i_ovf_clr)
        r_ovf <= 1'b0;
      else if (|(w_cap_en & r_pending & ~w_clr_mask))
        r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_out_idx   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_out_idx   <= w_idx_next;
      r_out_valid <= w_valid_next;
    end
  end

  // Index is latched on entry to PRESENT and frozen until the grant is accepted.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_out_idx;
    w_valid_next = r_out_valid;
    case (r_state)
      IDLE: begin
        if (|r_pending) begin
          w_idx_next   = w_high_idx;
          w_valid_next = 1'b1;
          w_state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (w_accept) begin
          w_valid_next = 1'b0;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_valid_next = 1'b0;
        w_state_next = IDLE;
      end
    endcase
  end

  assign o_pending          = r_pending;
  assign o_ovf              = r_ovf;
  assign grant_if.out_idx   = r_out_idx;
  assign grant_if.out_valid = r_out_valid;

endmodule

// File: tb/tb_priority_encoder_4to2_reg.sv
// Self-checking bench for priority_encoder_4to2_reg: directed scenarios plus random
// traffic compared against a cycle-level behavioural model of the pending/grant rules.
module tb_priority_encoder_4to2_reg;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] reqIn;
  logic       ovfClr;
  logic [3:0] pending;
  logic       ovf;

  int errorCount = 0;
  int checkCount = 0;

  // Behavioural model state
  int mPend;
  int mValid;
  int mIdx;
  int mOvf;
  int mReqPrev;

  int grantCount;
  int grants[$];
  int prevValid;

  priority_encoder_4to2_reg_if #(.W(2)) bus ();

  priority_encoder_4to2_reg #(.N(4), .W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (en),
    .i_req_in  (reqIn),
    .i_ovf_clr (ovfClr),
    .o_pending (pending),
    .o_ovf     (ovf),
    .grant_if  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual != expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic int highestSet(input int v);
    for (int i = 3; i >= 0; i--)
      if (v[i]) return i;
    return 0;
  endfunction

  task automatic modelReset();
    mPend = 0; mValid = 0; mIdx = 0; mOvf = 0; mReqPrev = 0;
  endtask

  task automatic compareAll();
    checkOutput("pending", pending, mPend);
    checkOutput("outValid", bus.out_valid, mValid);
    checkOutput("outIdx", bus.out_idx, mIdx);
    checkOutput("ovf", ovf, mOvf);
  endtask

  // One clock: drive inputs, advance the model across the edge, compare on the falling edge.
  task automatic applyStimulus(input bit e, input int req, input bit ready, input bit clr);
    int cap, clrMask, capEn, nPend, nOvf, nValid, nIdx;
    en = e; reqIn = req[3:0]; bus.out_ready = ready; ovfClr = clr;
`ifdef PRIO_ENC_EDGE_DETECT_EN
    cap = req & ~mReqPrev & 15;
`else
    cap = req & 15;
`endif
    clrMask = (mValid != 0 && ready) ? (1 << mIdx) : 0;
    capEn   = e ? cap : 0;
    nPend   = (mPend & ~clrMask) | capEn;
    nOvf    = clr ? 0 : ((mOvf != 0 || (capEn & mPend & ~clrMask) != 0) ? 1 : 0);
    nValid  = mValid;
    nIdx    = mIdx;
    if (mValid == 0) begin
      if (mPend != 0) begin
        nValid = 1;
        nIdx   = highestSet(mPend);
      end
    end else if (ready) begin
      nValid = 0;
    end
    @(posedge clk);
    mPend = nPend; mOvf = nOvf; mValid = nValid; mIdx = nIdx; mReqPrev = req & 15;
    @(negedge clk);
    compareAll();
  endtask

  task automatic doReset();
    rst_n = 1'b0; en = 1'b0; reqIn = 4'b0; ovfClr = 1'b0; bus.out_ready = 1'b0;
    modelReset();
    repeat (2) begin
      @(negedge clk);
      compareAll();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; reqIn = 4'b1111; ovfClr = 1'b0; bus.out_ready = 1'b1;
    modelReset();
    repeat (3) begin
      @(negedge clk);
      checkOutput("rstPending", pending, 0);
      checkOutput("rstValid", bus.out_valid, 0);
      checkOutput("rstOvf", ovf, 0);
    end
    rst_n = 1'b1;
    $display("[TB] reset phase done");

    // Single request
    doReset();
    applyStimulus(1, 4'b0100, 1, 0);
    checkOutput("singleValidEarly", bus.out_valid, 0);
    applyStimulus(1, 0, 1, 0);
    checkOutput("singleValid", bus.out_valid, 1);
    checkOutput("singleIdx", bus.out_idx, 2);
    applyStimulus(1, 0, 1, 0);
    checkOutput("singleCleared", pending, 0);
    checkOutput("singleDropped", bus.out_valid, 0);

    // Priority and drain
    doReset();
    grants.delete();
    prevValid = 0;
    applyStimulus(1, 4'b1011, 1, 0);
    repeat (10) begin
      applyStimulus(1, 0, 1, 0);
      if (bus.out_valid) begin
        checkOutput("drainIdleGap", prevValid, 0);
        grants.push_back(int'(bus.out_idx));
      end
      prevValid = int'(bus.out_valid);
    end
    checkOutput("drainCount", grants.size(), 3);
    if (grants.size() == 3) begin
      checkOutput("drainFirst", grants[0], 3);
      checkOutput("drainSecond", grants[1], 1);
      checkOutput("drainThird", grants[2], 0);
    end

    // Backpressure
    doReset();
    applyStimulus(1, 4'b0010, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("bpIdxInitial", bus.out_idx, 1);
    applyStimulus(1, 4'b1000, 0, 0);
    repeat (3) begin
      applyStimulus(1, 0, 0, 0);
      checkOutput("bpIdxFrozen", bus.out_idx, 1);
      checkOutput("bpValidHeld", bus.out_valid, 1);
    end
    applyStimulus(1, 0, 1, 0);
    checkOutput("bpAccepted", bus.out_valid, 0);
    applyStimulus(1, 0, 1, 0);
    checkOutput("bpNextIdx", bus.out_idx, 3);
    checkOutput("bpNextValid", bus.out_valid, 1);
    applyStimulus(1, 0, 1, 0);

    // Overflow and enable
    doReset();
    applyStimulus(1, 4'b0001, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 4'b0001, 0, 0);
    checkOutput("ovfSet", ovf, 1);
    applyStimulus(1, 0, 0, 1);
    checkOutput("ovfCleared", ovf, 0);
    applyStimulus(0, 4'b0001, 0, 0);
    checkOutput("enOffPending", pending, 1);
    checkOutput("enOffOvf", ovf, 0);
    applyStimulus(0, 4'b0001, 1, 0);
    checkOutput("enOffDrain", pending, 0);

    // Held-high line
    doReset();
    grantCount = 0;
    repeat (10) begin
      applyStimulus(1, 4'b0010, 1, 0);
      if (bus.out_valid) grantCount++;
    end
`ifdef PRIO_ENC_EDGE_DETECT_EN
    checkOutput("heldGrants", grantCount, 1);
`else
    checkOutput("heldGrants", grantCount, 5);
`endif
    repeat (3) applyStimulus(1, 0, 1, 0);

    // Async reset while a grant is presented
    doReset();
    applyStimulus(1, 4'b1000, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("asyncPreValid", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncValid", bus.out_valid, 0);
    checkOutput("asyncPending", pending, 0);
    modelReset();
    @(negedge clk);
    compareAll();
    rst_n = 1'b1;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 3) != 0,
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : 0,
                    $urandom_range(0, 1) == 1,
                    $urandom_range(0, 9) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
